// File: rtl/sram_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sram_cfg_pkg
// Purpose  : Shared constants and types for the SRAM bank array. Holds the
//            geometry of the gf180 512x8 macro and the bank FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package sram_cfg_pkg;

  localparam int MACRO_DEPTH = 512;  // words per macro
  localparam int MACRO_W     = 8;    // bits per macro word (one column)
  localparam int MACRO_AW    = 9;    // macro address width

  typedef enum logic [0:0] {
    INIT  = 1'b0,                    // post-reset clear sweep in progress
    READY = 1'b1                     // servicing core requests
  } state_e;

endpackage
`default_nettype wire

// File: rtl/gf180_ram_512x8_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : gf180_ram_512x8_wrapper
// Purpose  : Behavioural stand-in for the 512x8 gf180 SRAM macro wrapper.
//            Single port, synchronous, active-low controls. Q is registered
//            on a read and holds its value on writes and idle cycles.
// Ports    : CLK  - clock
//            CEN  - chip enable, active-low
//            GWEN - global write enable, active-low (1 = read)
//            WEN  - per-bit write enable, active-low
//            A    - word address
//            D    - write data
//            Q    - read data
// Revision : 1.0 - initial release
// ============================================================================
module gf180_ram_512x8_wrapper (
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [8:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);

  logic [7:0] mem_q [512];
  logic [7:0] q_q;

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        // Bits with WEN=1 keep their stored value.
        mem_q[A] <= (mem_q[A] & WEN) | (D & ~WEN);
      end else begin
        q_q <= mem_q[A];
      end
    end
  end

  assign Q = q_q;

endmodule
`default_nettype wire

// File: rtl/sram_bank_row.sv
`default_nettype none
// ============================================================================
// Module   : sram_bank_row
// Purpose  : One row of the bank: COLS macros side by side, sharing CEN,
//            GWEN and address, each owning one MACRO_W-bit column of data.
// Ports    : clk    - clock
//            cen_i  - row chip enable, active-low
//            gwen_i - row write enable, active-low
//            a_i    - macro word address
//            wen_i  - per-bit write enable, active-low, all columns
//            d_i    - write data, all columns
//            q_o    - read data, all columns
// Revision : 1.0 - initial release
// ============================================================================
module sram_bank_row
  import sram_cfg_pkg::*;
#(
  parameter int COLS = 4
) (
  input  logic                      clk,
  input  logic                      cen_i,
  input  logic                      gwen_i,
  input  logic [MACRO_AW-1:0]       a_i,
  input  logic [COLS*MACRO_W-1:0]   wen_i,
  input  logic [COLS*MACRO_W-1:0]   d_i,
  output logic [COLS*MACRO_W-1:0]   q_o
);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    gf180_ram_512x8_wrapper u_macro (
      .CLK  (clk),
      .CEN  (cen_i),
      .GWEN (gwen_i),
      .WEN  (wen_i[c*MACRO_W +: MACRO_W]),
      .A    (a_i),
      .D    (d_i[c*MACRO_W +: MACRO_W]),
      .Q    (q_o[c*MACRO_W +: MACRO_W])
    );
  end

endmodule
`default_nettype wire

// File: rtl/sram_bank_array.sv
`default_nettype none
// ============================================================================
// Module   : sram_bank_array
// Purpose  : Parametrised RAM bank built from 512x8 macros. Adds an optional
//            post-reset clear sweep (OUT_busy), a registered row-select read
//            mux and a read-data hold register so OUT_data stays stable
//            between reads. Upper CONST_W bits of OUT_data are not stored and
//            always read as CONST_VAL.
// Ports    : clk        - clock
//            rst        - synchronous active-high reset
//            IN_ce      - chip enable, active-low
//            IN_we      - write enable, active-low (1 with IN_ce=0 = read)
//            IN_addr    - word address
//            IN_data    - write data (constant upper bits ignored)
//            IN_wm      - per-column write mask, active-high
//            OUT_data   - read data
//            OUT_rvalid - one-cycle pulse when OUT_data carries a new read
//            OUT_busy   - clear sweep running, requests dropped
// Revision : 1.0 - initial release
// ============================================================================
module sram_bank_array
  import sram_cfg_pkg::*;
#(
  parameter int              DATA_W        = 32,
  parameter int              CONST_W       = 0,
  parameter logic [DATA_W-1:0] CONST_VAL   = '0,
  parameter int              ADDR_W        = 9,
  parameter bit              INIT_ON_RESET = 1'b1,
  parameter bit              INIT_VAL      = 1'b0,
  localparam int             STORE_W       = DATA_W - CONST_W,
  localparam int             COLS          = (STORE_W / MACRO_W > 0) ? STORE_W / MACRO_W : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IN_ce,
  input  logic                IN_we,
  input  logic [ADDR_W-1:0]   IN_addr,
  input  logic [DATA_W-1:0]   IN_data,
  input  logic [COLS-1:0]     IN_wm,
  output logic [DATA_W-1:0]   OUT_data,
  output logic                OUT_rvalid,
  output logic                OUT_busy
);

  localparam int ROWS    = (ADDR_W > MACRO_AW) ? (1 << (ADDR_W - MACRO_AW)) : 1;
  localparam int RIDX_W  = (ADDR_W > MACRO_AW) ? (ADDR_W - MACRO_AW) : 1;
  localparam int SWEEP_N = (ADDR_W < MACRO_AW) ? (1 << ADDR_W) : MACRO_DEPTH;
  localparam logic [MACRO_AW-1:0] SWEEP_LAST = MACRO_AW'(SWEEP_N - 1);

  // Elaboration checks
  if (STORE_W <= 0 || (STORE_W % MACRO_W) != 0) begin : g_err_width
    $error("sram_bank_array: stored width must be a positive multiple of the macro width");
  end
  if (ADDR_W > MACRO_AW && ((1 << ADDR_W) % MACRO_DEPTH) != 0) begin : g_err_depth
    $error("sram_bank_array: depth must be a multiple of the macro depth");
  end

  state_e                   state_q;
  logic                     busy_q;
  logic [MACRO_AW-1:0]      cnt_q;
  logic                     rvalid_q;
  logic [RIDX_W-1:0]        rsel_q;
  logic [STORE_W-1:0]       hold_q;
  logic [STORE_W-1:0]       hold_d;

  logic [MACRO_AW-1:0]      w_maddr;
  logic [RIDX_W-1:0]        w_row;
  logic                     w_sweep;
  logic                     w_req;
  logic                     w_rd;
  logic [ROWS-1:0]          w_cen;
  logic                     w_gwen;
  logic [STORE_W-1:0]       w_wen;
  logic [MACRO_AW-1:0]      w_a;
  logic [STORE_W-1:0]       w_d;
  logic [STORE_W-1:0]       w_rq [ROWS];
  logic [STORE_W-1:0]       w_qsel;

  // Address split: low bits address the macro, high bits pick the row.
  if (ADDR_W >= MACRO_AW) begin : g_addr_full
    assign w_maddr = IN_addr[MACRO_AW-1:0];
  end else begin : g_addr_narrow
    assign w_maddr = {{(MACRO_AW - ADDR_W){1'b0}}, IN_addr};
  end

  if (ADDR_W > MACRO_AW) begin : g_row_idx
    assign w_row = IN_addr[ADDR_W-1:MACRO_AW];
  end else begin : g_row_single
    assign w_row = '0;
  end

  // Reset blocks all macro traffic, so nothing is accepted in a reset cycle.
  assign w_sweep = (state_q == INIT) && !rst;
  assign w_req   = (state_q == READY) && !rst && !IN_ce;
  assign w_rd    = w_req && IN_we;

  always_comb begin
    w_cen  = '1;
    w_gwen = 1'b1;
    w_wen  = '1;
    w_a    = w_maddr;
    w_d    = IN_data[STORE_W-1:0];
    if (w_sweep) begin
      // Every row and column written at the sweep address in one cycle.
      w_cen  = '0;
      w_gwen = 1'b0;
      w_wen  = '0;
      w_a    = cnt_q;
      w_d    = {STORE_W{INIT_VAL}};
    end else if (w_req) begin
      w_gwen = IN_we;
      for (int c = 0; c < COLS; c++) begin
        w_wen[c*MACRO_W +: MACRO_W] = {MACRO_W{~IN_wm[c]}};
      end
      for (int r = 0; r < ROWS; r++) begin
        if (w_row == RIDX_W'(r)) w_cen[r] = 1'b0;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    sram_bank_row #(
      .COLS (COLS)
    ) u_row (
      .clk    (clk),
      .cen_i  (w_cen[r]),
      .gwen_i (w_gwen),
      .a_i    (w_a),
      .wen_i  (w_wen),
      .d_i    (w_d),
      .q_o    (w_rq[r])
    );
  end

  // Row registered alongside the macro read so the mux lines up with Q.
  assign w_qsel = w_rq[rsel_q];
  assign hold_d = rvalid_q ? w_qsel : hold_q;

  // Bank FSM: clear sweep then steady-state service.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_ON_RESET ? INIT : READY;
      busy_q  <= INIT_ON_RESET;
      cnt_q   <= '0;
    end else if (state_q == INIT) begin
      if (cnt_q == SWEEP_LAST) begin
        state_q <= READY;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rsel_q   <= '0;
      hold_q   <= '0;
    end else begin
      rvalid_q <= w_rd;
      if (w_rd) rsel_q <= w_row;
      hold_q   <= hold_d;
    end
  end

  // Fresh macro data on the completion cycle, held copy otherwise.
  assign OUT_data[STORE_W-1:0] = hold_d;
  assign OUT_rvalid            = rvalid_q;
  assign OUT_busy              = busy_q;

  if (CONST_W > 0) begin : g_const
    logic w_unused_const;
    assign OUT_data[DATA_W-1 -: CONST_W] = CONST_VAL[CONST_W-1:0];
    assign w_unused_const                = ^IN_data[DATA_W-1 -: CONST_W];
  end

endmodule
`default_nettype wire

// File: doc/sram_bank_array.md
Name: sram_bank_array

Overview:
Parametrised RAM bank built from gf180_ram_512x8_wrapper macros. It replaces the hand-instantiated per-byte cache/tag macro groups with a single block that is generic in data width, depth (multiple macro rows), byte-mask granularity and constant upper bits. It adds three things the hand-instantiated groups lack:
- an optional post-reset clear sweep with a busy output;
- a registered row-select read mux;
- a read-data hold register.
It sits between the core's cache/tag SRAM ports and the macros in the user project wrapper.

Parameters:
DATA_W, 32, logical word width seen by the core
CONST_W, 0, number of upper OUT_data bits that are constant and not stored
CONST_VAL, 0, value driven on OUT_data[DATA_W-1 -: CONST_W]
ADDR_W, 9, word address width
INIT_ON_RESET, 1, run the clear sweep after reset when 1
INIT_VAL, 0, value written to every stored bit during the sweep (replicated to STORE_W)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
IN_ce  in  1  chip enable, active-low (core cache-port convention)
IN_we  in  1  write enable, active-low; IN_we=1 with IN_ce=0 is a read
IN_addr  in  ADDR_W  word address
IN_data  in  DATA_W  write data; the constant upper bits are ignored
IN_wm  in  COLS  per-column write enable, active-high (one bit per MACRO_W-bit column)
OUT_data  out  DATA_W  read data
OUT_rvalid  out  1  one-cycle pulse when OUT_data carries new read data
OUT_busy  out  1  high while the clear sweep runs; requests are dropped

Behaviour:
- Derived values:
  - STORE_W = DATA_W-CONST_W
  - COLS = STORE_W/MACRO_W
  - ROWS = max(1, 2^ADDR_W/MACRO_DEPTH)
  - SWEEP_N = min(2^ADDR_W, MACRO_DEPTH)
- Elaboration errors:
  - STORE_W not a positive multiple of MACRO_W;
  - ADDR_W>MACRO_AW and 2^ADDR_W not a multiple of MACRO_DEPTH.
- Addressing:
  - Macro address = IN_addr[MACRO_AW-1:0], zero-extended when ADDR_W<MACRO_AW.
  - Row index = IN_addr[ADDR_W-1:MACRO_AW].
  - Only the selected row gets CEN=0; all other rows get CEN=1.
- Macro pin mapping:
  - GWEN = IN_we.
  - WEN per column = {MACRO_W{~IN_wm[c]}}.
  - D = the column's slice of IN_data.
- Read:
  - A read accepted in cycle t gives OUT_rvalid=1 in t+1.
  - OUT_data in t+1 = macro Q of the row registered at t (combinational path through the mux).
  - The same value is captured into the hold register at the end of t+1.
  - In all other cycles OUT_data = the hold register, so it stays stable until the next read completes.
- Write: updates only columns with IN_wm=1. OUT_rvalid stays 0 and OUT_data is unchanged (hold register).
- Constant bits: the upper CONST_W bits of OUT_data always equal CONST_VAL, including during reset and the sweep.
- Reset values: OUT_rvalid=0, hold register=0 (OUT_data stored bits=0), OUT_busy=INIT_ON_RESET, counter=0.
- FSM states: INIT, READY.
  - rst forces INIT if INIT_ON_RESET, otherwise READY.
- INIT:
  - Each cycle, every row and column is written: CEN=0, GWEN=0, WEN=all 0, A=counter, D=INIT_VAL.
  - counter++ each cycle; at counter==SWEEP_N-1 go to READY with OUT_busy=0 the next cycle.
  - Total busy time is exactly SWEEP_N cycles after rst deasserts.
  - Core requests are ignored (no macro access, no rvalid).
- READY: requests are serviced every cycle with no stalls. Back-to-back reads to different rows are allowed.
- rst asserted mid-sweep or mid-read:
  - the sweep restarts from 0;
  - a pending rvalid is cancelled;
  - the hold register is cleared.
- Read of a just-written address in the next cycle returns the new data (macro behaviour, no forwarding needed).

Decomposition:
- Package sram_cfg_pkg holds:
  - MACRO_DEPTH=512, MACRO_W=8, MACRO_AW=9;
  - the state enum {INIT, READY}.
- Sub-module sram_bank_row: one row of COLS gf180_ram_512x8_wrapper instances with shared CEN/GWEN/A, per-column WEN/D/Q. It is instantiated ROWS times.
- The top level holds the FSM, the sweep counter, the row decode, the registered row select, the read mux and the hold register.

Test Plan:
- DATA_W=32, ADDR_W=10 (ROWS=2), INIT_ON_RESET=1: deassert rst -> OUT_busy=1 for exactly 512 cycles then 0; a read of 0x3FF returns 0x00000000 with rvalid one cycle later.
- Write 0xDEADBEEF to 0x201 with wm=1111, then read 0x201 -> rvalid at t+1 with 0xDEADBEEF; ten idle cycles later OUT_data is still 0xDEADBEEF and rvalid=0.
- Byte mask: over 0xDEADBEEF, write 0x11223344 with wm=0101, then read -> 0xDE22BE44.
- Row select: write 0xA to 0x005 and 0xB to 0x205, then read 0x005 and 0x205 back-to-back -> 0xA then 0xB, each one cycle after its request.
- DATA_W=22, CONST_W=6, CONST_VAL=6'b100000, ADDR_W=7: write 0x3FFFFF to 0x7F, then read -> 0x20FFFF; OUT_busy lasts 128 cycles.
- Assert rst at sweep cycle 300 for one cycle -> busy stays high for a fresh 512 cycles; a write issued during busy is dropped (a later read of that address returns 0).
